// File: rtl/avl_pkg.sv
// Shared widths and stall-LFSR constants for the Avalon memory responder.
package avl_pkg;
    localparam int AVL_ADDR_W = 26;
    localparam int AVL_DATA_W = 128;
    localparam int SIZE_W     = 8;
    localparam int LFSR_W     = 16;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction
endpackage

// File: rtl/avl_read_pipe.sv
// Read-return delay line: DEPTH cycles from issue to response, no backpressure
// (the host must always sink readdatavalid beats).
module avl_read_pipe #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 3
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              issue_vld,
    input  logic [DATA_W-1:0] issue_dat,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_dat
);
    logic              vld_q [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue_vld;
            dat_q[0] <= issue_dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rsp_vld = vld_q[DEPTH-1];
    assign rsp_dat = dat_q[DEPTH-1];
endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM burst memory model: read data READ_LATENCY cycles after issue.
// waitrequest stalls pseudo-randomly, while a read burst issues, and on reset exit.
module avalon_mem_responder
    import avl_pkg::*;
#(
    parameter int                ADDR_W       = AVL_ADDR_W,
    parameter int                DATA_W       = AVL_DATA_W,
    parameter int                MEM_AW       = 8,
    parameter int                READ_LATENCY = 3,
    parameter logic [LFSR_W-1:0] STALL_SEED   = 16'hACE1
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] avl_address,
    input  logic [DATA_W-1:0] avl_writedata,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic              avl_burstbegin,
    input  logic [SIZE_W-1:0] avl_size,
    input  logic              stall_enable,
    output logic              avl_waitrequest,
    output logic              avl_readdatavalid,
    output logic [DATA_W-1:0] avl_readdata,
    output logic              error_flag
);
    localparam logic [MEM_AW-1:0] ONE_A = 1;
    localparam logic [SIZE_W-1:0] ONE_S = 1;

    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic [LFSR_W-1:0] lfsr;
    logic              rst_hold;
    logic [SIZE_W-1:0] rd_left;
    logic [MEM_AW-1:0] rd_addr;
    logic              wr_open;
    logic [SIZE_W-1:0] wr_left;
    logic [MEM_AW-1:0] wr_addr;

    logic              stall;
    logic              rd_busy;
    logic              accept;
    logic              acc_wr;
    logic              acc_rd;
    logic              wr_start;
    logic              rd_issue;
    logic              proto_err;
    logic [SIZE_W-1:0] burst_len;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic [MEM_AW-1:0] req_idx;
    logic              unused_addr;

    // Upper address bits are deliberately ignored: the RAM aliases modulo its depth.
    assign unused_addr = ^avl_address;
    assign req_idx     = avl_address[MEM_AW-1:0];

    always_comb begin
        stall           = stall_enable & (lfsr[1:0] == 2'b00);
        rd_busy         = (rd_left != '0);
        avl_waitrequest = rst_hold | rd_busy | stall;
        accept          = (avl_read | avl_write) & ~avl_waitrequest;
        acc_wr          = accept & avl_write;
        acc_rd          = accept & avl_read & ~avl_write;
        burst_len       = (avl_size == '0) ? ONE_S : avl_size;
        wr_start        = acc_wr & (avl_burstbegin | ~wr_open);
        wr_idx          = wr_start ? req_idx : wr_addr;
        rd_issue        = acc_rd | rd_busy;
        rd_idx          = rd_busy ? rd_addr : req_idx;
        proto_err       = (accept & avl_read & avl_write)
                        | (acc_wr & avl_burstbegin & wr_open)
                        | (acc_rd & wr_open);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            lfsr       <= STALL_SEED;
            rst_hold   <= 1'b1;
            rd_left    <= '0;
            rd_addr    <= '0;
            wr_open    <= 1'b0;
            wr_left    <= '0;
            wr_addr    <= '0;
            error_flag <= 1'b0;
        end else begin
            lfsr     <= lfsr_step(lfsr);
            rst_hold <= 1'b0;
            if (proto_err)
                error_flag <= 1'b1;

            if (acc_rd) begin
                rd_left <= burst_len - ONE_S;
                rd_addr <= req_idx + ONE_A;
            end else if (rd_busy) begin
                rd_left <= rd_left - ONE_S;
                rd_addr <= rd_addr + ONE_A;
            end

            if (acc_wr) begin
                wr_addr <= wr_idx + ONE_A;
                if (wr_start) begin
                    wr_left <= burst_len - ONE_S;
                    wr_open <= (burst_len > ONE_S);
                end else begin
                    wr_left <= wr_left - ONE_S;
                    wr_open <= (wr_left > ONE_S);
                end
            end else if (acc_rd) begin
                // a read aborts any open write burst
                wr_open <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; writes cannot be accepted while reset holds waitrequest.
    always_ff @(posedge iCLK) begin
        if (acc_wr)
            mem[wr_idx] <= avl_writedata;
    end

    avl_read_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (READ_LATENCY)
    ) u_read_pipe (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .issue_vld (rd_issue),
        .issue_dat (mem[rd_idx]),
        .rsp_vld   (avl_readdatavalid),
        .rsp_dat   (avl_readdata)
    );
endmodule

// File: doc/avalon_mem_responder.md
AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 26: Avalon word-address width.
REQ-002 SHALL have parameter DATA_W, default 128: data width.
REQ-003 SHALL have parameter MEM_AW, default 8: backing-RAM address bits (depth 2^MEM_AW words).
REQ-004 SHALL have parameter READ_LATENCY, default 3 (legal 1..8): cycles from read acceptance to first readdatavalid.
REQ-005 SHALL have parameter STALL_SEED, default 16'hACE1: stall-LFSR seed, never zero.
REQ-006 SHALL have port iCLK  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port iRST_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port avl_address  input  ADDR_W  word address of the first beat.
REQ-009 SHALL have port avl_writedata  input  DATA_W  write data.
REQ-010 SHALL have port avl_read  input  1  read request.
REQ-011 SHALL have port avl_write  input  1  write request.
REQ-012 SHALL have port avl_burstbegin  input  1  marks the first beat of a write burst.
REQ-013 SHALL have port avl_size  input  8  burst length in beats; 0 is treated as 1.
REQ-014 SHALL have port stall_enable  input  1  enables pseudo-random waitrequest insertion.
REQ-015 SHALL have port avl_waitrequest  output  1  active-high; request is not accepted while 1.
REQ-016 SHALL have port avl_readdatavalid  output  1  qualifies avl_readdata.
REQ-017 SHALL have port avl_readdata  output  DATA_W  read data.
REQ-018 SHALL have port error_flag  output  1  sticky protocol-error indicator.

Function
REQ-019 Acceptance SHALL be (avl_read | avl_write) & !avl_waitrequest, sampled at the rising edge of iCLK.
REQ-020 RAM index SHALL be (beat address) mod 2^MEM_AW; bits above MEM_AW SHALL be ignored; address increments SHALL wrap modulo 2^MEM_AW.
REQ-021 avl_waitrequest SHALL be the OR of: stall_enable & (lfsr[1:0]==2'b00); read-burst-issue busy (REQ-025); and the reset-exit cycle (REQ-032). The LFSR SHALL advance every cycle.
REQ-022 Write burst: an accepted beat with avl_burstbegin=1, or with no write burst open, SHALL latch base address A and length N, write beat 0 to A, and open a burst if N>1.
REQ-023 Each later accepted write beat k SHALL write to A+k, ignoring avl_address. The burst SHALL close after beat N-1. Stalls between beats SHALL be legal and SHALL NOT count as beats.
REQ-024 avl_burstbegin=1 while a write burst is open SHALL set error_flag and restart a new burst at the current avl_address.
REQ-025 Read: an accepted read at cycle t with length N SHALL issue internal RAM reads of A..A+N-1 at cycles t..t+N-1. avl_waitrequest SHALL be 1 during cycles t+1..t+N-1.
REQ-026 avl_readdatavalid SHALL be 1 in cycles t+READ_LATENCY .. t+READ_LATENCY+N-1 with contiguous data, and 0 otherwise.
REQ-027 Single-beat reads SHALL be accepted back-to-back, one per cycle, with no bubbles.
REQ-028 A read SHALL return RAM contents as of its internal issue cycle. A write accepted in an earlier cycle SHALL be visible.
REQ-029 avl_read & avl_write both high on an accepted cycle SHALL set error_flag, perform the write, and drop the read.
REQ-030 A read accepted while a write burst is open SHALL set error_flag, abort the write burst, and service the read.
REQ-031 error_flag SHALL be cleared only by reset.

Reset
REQ-032 iRST_n=0 SHALL asynchronously set avl_readdatavalid=0, avl_readdata=0 and error_flag=0, flush the read pipeline and burst counters, and load the LFSR with STALL_SEED. avl_waitrequest SHALL be 1 during reset and for the first cycle after release.
REQ-033 Reset mid-burst SHALL discard all outstanding read beats and open write bursts. RAM contents SHALL NOT be reset and SHALL be retained.

Structure
REQ-034 Package avl_pkg SHALL hold the ADDR_W/DATA_W defaults, the burst-size width (8), and the LFSR polynomial constant.
REQ-035 The read latency shift register (valid + data, READ_LATENCY stages) SHALL be the sub-module avl_read_pipe. The RAM and the stall LFSR SHALL remain inline.

Verification
REQ-036 Scenario: stall_enable=0; write burst A=0x10, N=4, data 1..4; then read A=0x10, N=4 -> writes never stalled; readdatavalid exactly 3 cycles after read acceptance for 4 cycles, data 1,2,3,4; waitrequest high 3 cycles after the read.
REQ-037 Scenario: stall_enable=1; 256 single-beat writes of an LFSR pattern; then 256 back-to-back reads -> all data match; every stalled cycle produces no beat; error_flag=0.
REQ-038 Scenario: write to address 0x3FFFFFF, then read 0xFF -> the written value is returned (wrap/truncation).
REQ-039 Scenario: read and write asserted together at address 5, data 0xAA -> error_flag=1, no readdatavalid, a later read of 5 returns 0xAA.
REQ-040 Scenario: iRST_n pulsed low 2 cycles after an N=8 read acceptance -> readdatavalid drops immediately and no further beats follow; waitrequest=1 for the first cycle after release; earlier RAM data is still readable.
